// File: rtl/prim_ram_pkg.sv
// ----------------------------------------------------------------------------
// prim_ram_pkg : shared FSM state type and counter width helper for the RAM
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package prim_ram_pkg;

  typedef enum logic [0:0] {
    RamIdle = 1'b0,
    RamInit = 1'b1
  } ram_init_state_e;

  function automatic int unsigned init_cnt_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prim_ram_init_ctrl.sv
// ----------------------------------------------------------------------------
// prim_ram_init_ctrl : Idle/Init FSM, zeroisation address counter, grant gating
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prim_ram_init_ctrl
  import prim_ram_pkg::*;
#(
  parameter int unsigned Depth       = 128,
  parameter bit          InitOnReset = 1'b1,
  parameter int unsigned Aw          = init_cnt_width(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          init_req_i,
  output logic          gnt_o,
  output logic          init_busy_o,
  output logic          init_done_o,
  output logic          init_we_o,
  output logic [Aw-1:0] init_addr_o
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  ram_init_state_e state_q, state_d;
  logic [Aw-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  // init_req_i is only looked at in Idle, so a request during Init never restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      RamIdle: begin
        if (init_req_i) begin
          state_d = RamInit;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      RamInit: begin
        if (cnt_q == LastAddr) begin
          state_d = RamIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RamIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= InitOnReset ? RamInit : RamIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt_o       = req_i && (state_q == RamIdle);
  assign init_busy_o = (state_q == RamInit);
  assign init_we_o   = (state_q == RamInit);
  assign init_addr_o = cnt_q;
  assign init_done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/prim_generic_ram_1p_init.sv
// ----------------------------------------------------------------------------
// prim_generic_ram_1p_init : single-port RAM with group write mask and zeroisation
// Revision                 : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prim_generic_ram_1p_init
  import prim_ram_pkg::*;
#(
  parameter int unsigned Width           = 32,
  parameter int unsigned Depth           = 128,
  parameter int unsigned DataBitsPerMask = 1,
  parameter bit          OutputReg       = 1'b0,
  parameter bit          InitOnReset     = 1'b1,
  localparam int unsigned Aw             = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  input  logic             init_req_i,
  output logic             gnt_o,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic             init_busy_o,
  output logic             init_done_o
);

  localparam int unsigned NumGroups = Width / DataBitsPerMask;

  logic             gnt;
  logic             init_we;
  logic [Aw-1:0]    init_addr;
  logic             addr_ok;
  logic [Width-1:0] wbitmask;

  prim_ram_init_ctrl #(
    .Depth       (Depth),
    .InitOnReset (InitOnReset),
    .Aw          (Aw)
  ) u_init_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .init_req_i  (init_req_i),
    .gnt_o       (gnt),
    .init_busy_o (init_busy_o),
    .init_done_o (init_done_o),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  assign gnt_o   = gnt;
  assign addr_ok = ({1'b0, addr_i} < (Aw + 1)'(Depth));

  // A group is written only when every mask bit in it is set.
  for (genvar g = 0; g < NumGroups; g++) begin : g_mask
    assign wbitmask[g*DataBitsPerMask +: DataBitsPerMask] =
        {DataBitsPerMask{&wmask_i[g*DataBitsPerMask +: DataBitsPerMask]}};
  end

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem_q[init_addr] <= '0;
    end else if (gnt && write_i && addr_ok) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~wbitmask) | (wdata_i & wbitmask);
    end
  end

  logic             rvalid_q, rvalid_d;
  logic [Width-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = gnt && !write_i;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rdata_d = addr_ok ? mem_q[addr_i] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  if (OutputReg) begin : g_out_reg
    logic             out_rvalid_q, out_rvalid_d;
    logic [Width-1:0] out_rdata_q, out_rdata_d;

    always_comb begin
      out_rvalid_d = rvalid_q;
      out_rdata_d  = rvalid_q ? rdata_q : out_rdata_q;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        out_rvalid_q <= 1'b0;
        out_rdata_q  <= '0;
      end else begin
        out_rvalid_q <= out_rvalid_d;
        out_rdata_q  <= out_rdata_d;
      end
    end

    assign rvalid_o = out_rvalid_q;
    assign rdata_o  = out_rdata_q;
  end else begin : g_no_out_reg
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_prim_generic_ram_1p_init.sv
// ----------------------------------------------------------------------------
// tb_prim_generic_ram_1p_init : directed table, corner sequences and random traffic
// Revision                    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_prim_generic_ram_1p_init;

  localparam int W  = 32;
  localparam int D  = 12;
  localparam int DB = 8;
  localparam int OR = 1;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  wmask;
  logic          init_req;
  logic          gnt_o;
  logic          rvalid_o;
  logic [W-1:0]  rdata_o;
  logic          init_busy_o;
  logic          init_done_o;

  prim_generic_ram_1p_init #(
    .Width           (W),
    .Depth           (D),
    .DataBitsPerMask (DB),
    .OutputReg       (1'b1),
    .InitOnReset     (1'b1)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .write_i     (wr),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .wmask_i     (wmask),
    .init_req_i  (init_req),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .init_busy_o (init_busy_o),
    .init_done_o (init_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, remaining-init bookkeeping, queue of reads due.
  typedef struct { int due; logic [W-1:0] data; } rd_t;
  rd_t          rq[$];
  logic [W-1:0] m_mem [D];
  bit           m_init, m_done, m_rvalid, mv;
  int           m_next, cyc;
  logic [W-1:0] m_rdata;

  task automatic model_edge();
    if (!rst_n) begin
      m_init = 1; m_next = 0; m_done = 0;
      rq.delete(); m_rdata = '0; mv = 1;
    end else if (m_init) begin
      m_mem[m_next] = '0;
      m_next++;
      if (m_next == D) begin m_init = 0; m_done = 1; end
    end else begin
      if (req && wr && addr < D) begin
        for (int g = 0; g < W / DB; g++)
          if (&wmask[g*DB +: DB]) m_mem[addr][g*DB +: DB] = wdata[g*DB +: DB];
      end else if (req && !wr) begin
        rq.push_back('{cyc + 1 + OR, (addr < D) ? m_mem[addr] : '0});
      end
      if (init_req) begin m_init = 1; m_next = 0; m_done = 0; end
    end
    cyc++;
    m_rvalid = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      m_rvalid = 1;
      m_rdata  = rq[0].data;
      void'(rq.pop_front());
    end
  endtask

  // Inputs are set by the caller; outputs are checked at the falling edge.
  task automatic cycle();
    @(negedge clk);
    if (mv) begin
      chk("gnt", W'(gnt_o), W'(req && !m_init));
      chk("init_busy", W'(init_busy_o), W'(m_init));
      chk("init_done", W'(init_done_o), W'(m_done));
      chk("rvalid", W'(rvalid_o), W'(m_rvalid));
      chk("rdata", rdata_o, m_rdata);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (init_busy_o && n < 200) begin
      n++;
      cycle();
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  wmask;
    logic [W-1:0]  exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] pat;
    bit seen;

    tbl[0]  = '{1'b1, 4'd3,  32'hAABBCCDD, 32'hFFFFFFFF, 32'h0};
    tbl[1]  = '{1'b1, 4'd3,  32'h11223344, 32'h00FF00F0, 32'h0};
    tbl[2]  = '{1'b1, 4'd13, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0};
    tbl[3]  = '{1'b0, 4'd3,  32'h0,        32'h0,        32'hAA22CCDD};
    tbl[4]  = '{1'b0, 4'd13, 32'h0,        32'h0,        32'h00000000};
    tbl[5]  = '{1'b0, 4'd11, 32'h0,        32'h0,        32'h00000000};
    tbl[6]  = '{1'b1, 4'd11, 32'h12345678, 32'h0000FFFF, 32'h0};
    tbl[7]  = '{1'b0, 4'd11, 32'h0,        32'h0,        32'h00005678};
    tbl[8]  = '{1'b1, 4'd0,  32'hCAFEF00D, 32'hFF0000FF, 32'h0};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,        32'h0,        32'hCA00000D};
    tbl[10] = '{1'b0, 4'd14, 32'h0,        32'h0,        32'h00000000};
    tbl[11] = '{1'b0, 4'd3,  32'h0,        32'h0,        32'hAA22CCDD};

    mv = 0; cyc = 0; m_rvalid = 0; m_rdata = '0;
    rst_n = 0; req = 1; wr = 0; addr = 4'd5; wdata = '0; wmask = '0; init_req = 0;

    // Reset with a read request held: no grant until the post-reset Init finishes.
    repeat (3) cycle();
    chk("reset_rvalid", W'(rvalid_o), '0);
    chk("reset_rdata", rdata_o, '0);
    chk("reset_done", W'(init_done_o), '0);
    rst_n = 1;
    count_busy(n);
    chk("init_len_reset", W'(n), W'(D));
    chk("done_after_init", W'(init_done_o), W'(1));
    repeat (3) cycle();
    chk("first_read_valid", W'(rvalid_o), W'(1));
    chk("first_read_zero", rdata_o, '0);
    req = 0;
    repeat (3) cycle();

    for (int i = 0; i < 12; i++) begin
      req = 1; wr = tbl[i].wr; addr = tbl[i].addr;
      wdata = tbl[i].wdata; wmask = tbl[i].wmask;
      cycle();
      req = 0;
      cycle();
      if (!tbl[i].wr) begin
        chk("tbl_rvalid", W'(rvalid_o), W'(1));
        chk("tbl_rdata", rdata_o, tbl[i].exp);
      end else begin
        chk("tbl_wr_no_rvalid", W'(rvalid_o), '0);
      end
    end
    cycle();

    // Back-to-back reads land on back-to-back cycles two cycles later.
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      req = (k < 3); wr = 0;
      addr = (k == 0) ? 4'd3 : (k == 1) ? 4'd11 : 4'd0;
      cycle();
      pat[k] = rvalid_o;
    end
    chk("b2b_pattern", W'(pat), W'(6'b001110));

    // Init request alongside a granted read, then a re-request inside Init.
    req = 1; wr = 0; addr = 4'd3; init_req = 1;
    cycle();
    req = 0; init_req = 0; n = 0; seen = 0;
    while (init_busy_o && n < 200) begin
      init_req = (n == 3);
      n++;
      cycle();
      seen |= rvalid_o;
    end
    init_req = 0;
    chk("init_len_rereq", W'(n), W'(D));
    chk("inflight_read_seen", W'(seen), W'(1));
    cycle();

    // Reset at Init cycle 5 restarts the full sweep.
    init_req = 1;
    cycle();
    init_req = 0;
    repeat (5) cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("done_low_after_rst", W'(init_done_o), '0);
    count_busy(n);
    chk("init_len_midreset", W'(n), W'(D));
    chk("done_after_restart", W'(init_done_o), W'(1));

    for (int i = 0; i < 400; i++) begin
      req      = ($urandom_range(0, 3) != 0);
      wr       = $urandom_range(0, 1) == 1;
      addr     = AW'($urandom_range(0, 15));
      wdata    = $urandom;
      init_req = ($urandom_range(0, 39) == 0);
      for (int b = 0; b < W / DB; b++) begin
        case ($urandom_range(0, 2))
          0:       wmask[b*DB +: DB] = '0;
          1:       wmask[b*DB +: DB] = '1;
          default: wmask[b*DB +: DB] = DB'($urandom);
        endcase
      end
      cycle();
    end
    req = 0; init_req = 0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prim_generic_ram_1p_init.md
PRIM_GENERIC_RAM_1P_INIT -- requirements
Module: prim_generic_ram_1p_init

Interface
REQ-001 SHALL have parameter Width, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter Depth, default 128, number of words (>=2, need not be a power of two).
REQ-003 SHALL have parameter DataBitsPerMask, default 1, bits per write-mask group; Width SHALL be a multiple of it.
REQ-004 SHALL have parameter OutputReg, default 0, 1 adds a read output register stage.
REQ-005 SHALL have parameter InitOnReset, default 1, 1 zeroises memory automatically after reset.
REQ-006 SHALL have localparam Aw = $clog2(Depth).
REQ-007 One clock; reset is synchronous and active-low: clk_i input 1 clock, all logic on rising edge.
REQ-008 rst_ni  input  1  synchronous active-low reset.
REQ-009 req_i  input  1  access request, held by requester until granted.
REQ-010 write_i  input  1  1 write, 0 read; qualified by req_i.
REQ-011 addr_i  input  Aw  word address.
REQ-012 wdata_i  input  Width  write data.
REQ-013 wmask_i  input  Width  per-bit write mask.
REQ-014 init_req_i  input  1  single-cycle request to zeroise memory.
REQ-015 gnt_o  output  1  access accepted this cycle.
REQ-016 rvalid_o  output  1  rdata_o valid this cycle.
REQ-017 rdata_o  output  Width  read data.
REQ-018 init_busy_o  output  1  zeroisation in progress.
REQ-019 init_done_o  output  1  sticky, at least one zeroisation completed since reset.

Function
REQ-020 FSM states Idle and Init; gnt_o SHALL equal req_i in Idle and 0 in Init (combinational).
REQ-021 Idle->Init on init_req_i=1; Init->Idle on the cycle counter writes word Depth-1; init_req_i in Init SHALL be ignored (no restart).
REQ-022 In Init, one word per cycle SHALL be written all-zero, addresses 0..Depth-1 ascending; Init SHALL last exactly Depth cycles; init_busy_o=1 throughout.
REQ-023 init_done_o SHALL clear on entry to Init and set on the Init->Idle transition, holding until next Init or reset.
REQ-024 Granted write: mask group g SHALL be written only if all DataBitsPerMask bits of wmask_i in group g are 1; other groups unchanged.
REQ-025 Granted read: rvalid_o SHALL pulse exactly 1+OutputReg cycles after grant, one pulse per granted read; back-to-back reads SHALL give back-to-back rvalid_o.
REQ-026 rdata_o SHALL hold its last value when rvalid_o=0; granted writes SHALL not alter rdata_o or rvalid_o.
REQ-027 addr_i >= Depth: write SHALL be dropped; read SHALL return all-zero with normal rvalid_o timing.
REQ-028 init_req_i coincident with a granted access: access SHALL complete, Init SHALL start next cycle; reads in flight SHALL still deliver rvalid_o.
REQ-029 A read of word A granted after Init completes SHALL return zero unless A was written after Init.

Reset
REQ-030 While rst_ni=0 at clk_i edge: rvalid_o=0, rdata_o=0, init_done_o=0, output pipeline cleared, counter=0.
REQ-031 Reset state SHALL be Init if InitOnReset=1, else Idle; init_busy_o reflects it the cycle after reset.
REQ-032 Reset mid-Init SHALL restart the counter at 0; contents are undefined until the next Init completes; memory array itself is not reset.

Structure
REQ-033 FSM state enum and init-counter width function SHALL live in shared package prim_ram_pkg.
REQ-034 FSM plus address counter SHALL be sub-module prim_ram_init_ctrl; storage and read pipeline stay in the top.

Verification
REQ-035 Depth=16, InitOnReset=1: release reset -> init_busy_o 16 cycles, gnt_o=0 with req_i=1 held, then init_done_o=1, first read of any address returns 0.
REQ-036 Width=32, DataBitsPerMask=8: write 0xAABBCCDD mask 0xFFFFFFFF, then write 0x11223344 mask 0x00FF00F0 -> read returns 0xAA22CCDD.
REQ-037 OutputReg=1: reads granted cycles 10,11,12 -> rvalid_o high cycles 12,13,14 with matching data.
REQ-038 Depth=12: write addr 13 then read addr 13 -> read returns 0, rvalid_o on time; addr 0..11 unaffected.
REQ-039 init_req_i with granted read same cycle, then init_req_i again at Init cycle 3 -> read rvalid_o delivered, Init lasts exactly Depth cycles.
REQ-040 rst_ni low at Init cycle 5 -> counter restarts, Init lasts full Depth cycles after release, init_done_o 0 until done.
